// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the data-memory arbiter between the CPU MEM stage
// and the debug/loader master.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } grant_t;

    localparam int STALL_CNT_W = 32;

    // Width needed to hold a starvation count of 0..starve_max inclusive.
    function automatic int starve_w(input int starve_max);
        return $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts CPU grants taken while the debug port was waiting; once the count reaches
// STARVE_MAX the debug port is forced to win the next arbitration.
module arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_grant,
    input  logic dbg_grant,
    input  logic dbg_waiting,
    output logic force_dbg
);

    localparam int CNT_W = starve_w(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (dbg_grant) begin
            count_reg <= '0;
        end else if (cpu_grant && dbg_waiting && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign force_dbg = (count_reg == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one fixed-latency data memory between the CPU MEM stage and a debug/loader master,
// one access at a time: IDLE (arbitrate) -> ACCESS x MEM_LAT -> DONE -> IDLE.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cpu_req_i,
    input  logic                   cpu_we_i,
    input  logic [ADDR_W-1:0]      cpu_addr_i,
    input  logic [DATA_W-1:0]      cpu_wdata_i,
    output logic [DATA_W-1:0]      cpu_rdata_o,
    output logic                   cpu_stall_o,
    input  logic                   dbg_req_i,
    input  logic                   dbg_we_i,
    input  logic [ADDR_W-1:0]      dbg_addr_i,
    input  logic [DATA_W-1:0]      dbg_wdata_i,
    output logic [DATA_W-1:0]      dbg_rdata_o,
    output logic                   dbg_ack_o,
    output logic                   mem_en_o,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_wdata_o,
    input  logic [DATA_W-1:0]      mem_rdata_i,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

    arb_state_t             state_reg, state_next;
    grant_t                 grant_reg, grant_next;
    logic [LAT_W-1:0]       lat_reg, lat_next;
    logic                   we_reg;
    logic [ADDR_W-1:0]      addr_reg;
    logic [DATA_W-1:0]      wdata_reg;
    logic [DATA_W-1:0]      cpu_rdata_reg, dbg_rdata_reg;
    logic [STALL_CNT_W-1:0] stall_cnt_reg;

    logic force_dbg;
    logic dbg_wins;
    logic launch;
    logic first_access;
    logic last_access;

    assign dbg_wins     = dbg_req_i & (~cpu_req_i | force_dbg);
    assign first_access = (state_reg == ACCESS) && (lat_reg == LAT_LOAD);
    assign last_access  = (state_reg == ACCESS) && (lat_reg == '0);

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        lat_next   = lat_reg;
        launch     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    state_next = ACCESS;
                    grant_next = dbg_wins ? GNT_DBG : GNT_CPU;
                    lat_next   = LAT_LOAD;
                    launch     = 1'b1;
                end
            end
            ACCESS: begin
                if (lat_reg == '0) begin
                    state_next = DONE;
                end else begin
                    lat_next = lat_reg - 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            grant_reg <= GNT_CPU;
            lat_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            lat_reg   <= lat_next;
            if (launch) begin
                we_reg    <= dbg_wins ? dbg_we_i : cpu_we_i;
                addr_reg  <= (dbg_wins ? dbg_addr_i : cpu_addr_i) & ADDR_MASK;
                wdata_reg <= dbg_wins ? dbg_wdata_i : cpu_wdata_i;
            end
        end
    end

    // Read data lands in the last access cycle; writes leave both read registers untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_rdata_reg <= '0;
            dbg_rdata_reg <= '0;
        end else if (last_access && !we_reg) begin
            if (grant_reg == GNT_DBG) begin
                dbg_rdata_reg <= mem_rdata_i;
            end else begin
                cpu_rdata_reg <= mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else if (cpu_stall_o && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk         (clk_i),
        .rst         (rst_i),
        .cpu_grant   (launch & ~dbg_wins),
        .dbg_grant   (launch & dbg_wins),
        .dbg_waiting (dbg_req_i),
        .force_dbg   (force_dbg)
    );

    assign cpu_stall_o = cpu_req_i & ~((state_reg == DONE) && (grant_reg == GNT_CPU));
    assign dbg_ack_o   = (state_reg == DONE) && (grant_reg == GNT_DBG);
    assign mem_en_o    = (state_reg == ACCESS);
    assign mem_we_o    = first_access & we_reg;
    assign mem_addr_o  = addr_reg;
    assign mem_wdata_o = wdata_reg;
    assign cpu_rdata_o = cpu_rdata_reg;
    assign dbg_rdata_o = dbg_rdata_reg;
    assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed checks of dmem_arbiter against a transaction-slot model:
// each granted access occupies MEM_LAT+2 cycles and memory effects follow grant order.
module tb_dmem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i, dbg_addr_i, dbg_wdata_i;
    logic [31:0] cpu_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i, stall_cnt_o;
    logic        cpu_stall_o, dbg_ack_o, mem_en_o, mem_we_o;

    logic [31:0] mem_arr [0:63];
    logic [31:0] ref_mem [0:63];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // slot model state
    int          next_idle = 0;
    int          gnt_cyc   = -100;
    int          done_cyc  = -100;
    bit          cur_d, cur_we;
    logic [31:0] cur_addr, cur_wdata;
    logic [31:0] exp_cpu_rd = 0, exp_dbg_rd = 0;
    int          starve = 0;
    int          model_stall = 0;
    bit          ev_c_done, ev_d_ack, ev_d_gnt;

    // observed events
    int obs_cdone_cyc = 0, obs_cdone_count = 0;
    int obs_ack_cyc = 0, obs_ack_count = 0, obs_we_count = 0;

    // driver state
    bit d_busy = 0, d_granted = 0;

    always #5 clk_i = ~clk_i;

    assign mem_rdata_i = mem_arr[mem_addr_o[7:2]];

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_cnt_o(stall_cnt_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h cyc=%0d", tag, got, want, cyc);
        end
    endtask

    // Runs at the negedge of cycle cyc: compares outputs with the slot model, then arbitrates.
    task automatic model_check();
        bit in_acc, is_done, e_stall, e_ack, e_we;
        int idx;
        ev_c_done = 0;
        ev_d_ack  = 0;
        ev_d_gnt  = 0;
        in_acc  = (cyc > gnt_cyc) && (cyc <= gnt_cyc + MEM_LAT);
        is_done = (cyc == done_cyc);
        e_we    = in_acc && (cyc == gnt_cyc + 1) && cur_we;
        e_stall = cpu_req_i && !(is_done && !cur_d);
        e_ack   = is_done && cur_d;
        check_val("stall", 32'(cpu_stall_o), 32'(e_stall));
        check_val("ack", 32'(dbg_ack_o), 32'(e_ack));
        check_val("mem_en", 32'(mem_en_o), 32'(in_acc));
        check_val("mem_we", 32'(mem_we_o), 32'(e_we));
        if (in_acc) check_val("mem_addr", mem_addr_o, cur_addr & 32'hFFFF_FFFC);
        if (e_we) check_val("mem_wdata", mem_wdata_o, cur_wdata);
        if (is_done && !cur_d) begin
            check_val("cpu_rdata", cpu_rdata_o, exp_cpu_rd);
            check_val("stall_cnt", stall_cnt_o, 32'(model_stall));
            ev_c_done = 1;
        end
        if (e_ack) begin
            check_val("dbg_rdata", dbg_rdata_o, exp_dbg_rd);
            ev_d_ack = 1;
        end
        if (is_done)
            $display("txn cyc=%0d port=%s we=%0d addr=%h wdata=%h rdata=%h", cyc,
                     cur_d ? "D" : "C", cur_we, cur_addr, cur_wdata,
                     cur_d ? dbg_rdata_o : cpu_rdata_o);
        if (cpu_req_i && !cpu_stall_o) begin
            obs_cdone_cyc = cyc;
            obs_cdone_count++;
        end
        if (dbg_ack_o) begin
            obs_ack_cyc = cyc;
            obs_ack_count++;
        end
        if (mem_we_o) begin
            obs_we_count++;
            mem_arr[mem_addr_o[7:2]] = mem_wdata_o;
        end
        if (e_stall) model_stall++;
        if (cyc == next_idle) begin
            if (cpu_req_i || dbg_req_i) begin
                cur_d     = dbg_req_i && (!cpu_req_i || starve == STARVE_MAX);
                cur_we    = cur_d ? dbg_we_i : cpu_we_i;
                cur_addr  = cur_d ? dbg_addr_i : cpu_addr_i;
                cur_wdata = cur_d ? dbg_wdata_i : cpu_wdata_i;
                gnt_cyc   = cyc;
                done_cyc  = cyc + MEM_LAT + 1;
                next_idle = done_cyc + 1;
                idx = int'(cur_addr[7:2]);
                if (cur_we) ref_mem[idx] = cur_wdata;
                else if (cur_d) exp_dbg_rd = ref_mem[idx];
                else exp_cpu_rd = ref_mem[idx];
                if (cur_d) begin
                    starve   = 0;
                    ev_d_gnt = 1;
                end else if (dbg_req_i && starve < STARVE_MAX) begin
                    starve++;
                end
            end else begin
                next_idle = cyc + 1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        model_check();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic c_issue(input bit we, input logic [31:0] a, input logic [31:0] d);
        cpu_req_i = 1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
    endtask

    task automatic d_issue(input bit we, input logic [31:0] a, input logic [31:0] d);
        dbg_req_i = 1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d;
        d_busy = 1; d_granted = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (!cpu_req_i && !dbg_req_i && cyc > done_cyc) break;
            step();
            if (ev_c_done) cpu_req_i = 0;
            if (ev_d_ack) begin
                dbg_req_i = 0;
                d_busy = 0;
            end
        end
        check_val("drain_idle", 32'(cpu_req_i || dbg_req_i || cyc <= done_cyc), 32'd0);
    endtask

    initial begin
        int a0, c0, w0, n_c;
        rst_i = 1;
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
        dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[0] = 32'd5;
        ref_mem[0] = 32'd5;
        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst_mem_en", 32'(mem_en_o), 0);
        check_val("rst_mem_we", 32'(mem_we_o), 0);
        check_val("rst_ack", 32'(dbg_ack_o), 0);
        check_val("rst_stall", 32'(cpu_stall_o), 0);
        check_val("rst_stall_cnt", stall_cnt_o, 0);
        check_val("rst_mem_addr", mem_addr_o, 0);
        check_val("rst_cpu_rdata", cpu_rdata_o, 0);
        rst_i = 0;

        // uncontended load of 5 from 0x00
        c_issue(0, 32'h00, 0);
        drain();
        check_val("ld_stall_cnt", stall_cnt_o, 32'd3);
        check_val("ld_rdata", cpu_rdata_o, 32'd5);

        // store 0x1234 to 0x04 then read it back
        w0 = obs_we_count;
        c_issue(1, 32'h04, 32'h1234);
        drain();
        check_val("st_we_pulses", 32'(obs_we_count - w0), 32'd1);
        check_val("st_mem", mem_arr[1], 32'h1234);
        c_issue(0, 32'h04, 0);
        drain();
        check_val("st_reread", cpu_rdata_o, 32'h1234);

        // simultaneous C and D from idle: C first, D ack 4 cycles after C's DONE
        c_issue(0, 32'h08, 0);
        d_issue(0, 32'h10, 0);
        drain();
        check_val("cd_gap", 32'(obs_ack_cyc - obs_cdone_cyc), 32'd4);

        // C held continuously while D waits
        d_issue(0, 32'h30, 0);
        c_issue(0, 32'h40, 0);
        c0 = obs_cdone_count;
        a0 = obs_ack_count;
        n_c = -1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (obs_ack_count != a0) begin
                n_c = obs_cdone_count - c0;
                dbg_req_i = 0;
                d_busy = 0;
                break;
            end
            if (ev_c_done) c_issue(0, 32'h40 + 32'(4 * i), 0);
        end
        check_val("starve_c_first", 32'(n_c), 32'd4);
        drain();

        // reset in the 2nd ACCESS cycle of a C read
        c_issue(0, 32'h20, 0);
        step();
        step();
        check_val("rst_pre_en", 32'(mem_en_o), 1);
        rst_i = 1;
        #1;
        check_val("rstm_mem_en", 32'(mem_en_o), 0);
        check_val("rstm_mem_we", 32'(mem_we_o), 0);
        check_val("rstm_ack", 32'(dbg_ack_o), 0);
        check_val("rstm_stall", 32'(cpu_stall_o), 1);
        check_val("rstm_cpu_rdata", cpu_rdata_o, 0);
        check_val("rstm_dbg_rdata", dbg_rdata_o, 0);
        check_val("rstm_stall_cnt", stall_cnt_o, 0);
        cpu_req_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 0;
        cyc += 2;
        next_idle = cyc; gnt_cyc = -100; done_cyc = -100;
        starve = 0; model_stall = 0; exp_cpu_rd = 0; exp_dbg_rd = 0;
        a0 = obs_ack_count;
        repeat (5) step();
        check_val("rstm_no_ack", 32'(obs_ack_count - a0), 0);

        // misaligned debug write to 0x0B
        a0 = obs_ack_count;
        d_issue(1, 32'h0B, 32'hCAFE);
        drain();
        check_val("mis_ack_pulses", 32'(obs_ack_count - a0), 32'd1);
        check_val("mis_mem", mem_arr[2], 32'hCAFE);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step();
            if (ev_d_gnt) d_granted = 1;
            if (ev_d_ack) begin
                dbg_req_i = 0;
                d_busy = 0;
            end
            if (!cpu_req_i || ev_c_done) begin
                if ($urandom_range(0, 9) < 6)
                    c_issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
                else
                    cpu_req_i = 0;
            end
            if (!d_busy) begin
                if ($urandom_range(0, 9) < 4)
                    d_issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
            end else if (d_granted && dbg_req_i && $urandom_range(0, 3) == 0) begin
                dbg_req_i = 0;
            end
        end
        drain();
        check_val("final_stall_cnt", stall_cnt_o, 32'(model_stall));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
